// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder: request side with
// valid/ready, FIFO head side with valid/ready, plus statistics counters.
interface imm_encoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       imm_sel;
    logic [31:0]      imm_val;
    logic [31:0]      base_inst;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst_out;
    logic             out_err;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, imm_sel, imm_val, base_inst, out_ready,
        input  in_ready, out_valid, inst_out, out_err, enc_cnt, err_cnt
    );

    modport slave (
        input  in_valid, imm_sel, imm_val, base_inst, out_ready,
        output in_ready, out_valid, inst_out, out_err, enc_cnt, err_cnt
    );
endinterface

// File: rtl/imm_encoder.sv
// Scatters an immediate into the I/S/B/U/J immediate fields of a RISC-V word,
// flags range/alignment/format errors and queues results in a small FIFO.
module imm_encoder #(
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16,
    parameter int STRICT = 0
) (
    input logic         clk,
    input logic         rst,
    imm_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // An immediate fits when it equals its own sign extension from the field's top bit.
    function automatic logic i_range_err(input logic [31:0] imm);
        return imm != {{20{imm[11]}}, imm[11:0]};
    endfunction

    function automatic logic b_range_err(input logic [31:0] imm);
        return (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
    endfunction

    function automatic logic j_range_err(input logic [31:0] imm);
        return (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
    endfunction

    logic [31:0] inst_mem_r [DEPTH];
    logic        err_mem_r  [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [CNT_W-1:0] enc_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic [31:0] enc_word_s;
    logic        enc_err_s;
    logic        full_s;
    logic        empty_s;
    logic        accept_s;
    logic        push_s;
    logic        pop_s;

    // Field scatter and error detection for the current request.
    always_comb begin
        enc_word_s = bus.base_inst;
        enc_err_s  = 1'b0;
        case (bus.imm_sel)
            3'd0: begin
                enc_word_s = {bus.imm_val[11:0], bus.base_inst[19:0]};
                enc_err_s  = i_range_err(bus.imm_val);
            end
            3'd1: begin
                enc_word_s = {bus.imm_val[11:5], bus.base_inst[24:12],
                              bus.imm_val[4:0], bus.base_inst[6:0]};
                enc_err_s  = i_range_err(bus.imm_val);
            end
            3'd2: begin
                enc_word_s = {bus.imm_val[12], bus.imm_val[10:5], bus.base_inst[24:12],
                              bus.imm_val[4:1], bus.imm_val[11], bus.base_inst[6:0]};
                enc_err_s  = b_range_err(bus.imm_val);
            end
            3'd3: begin
                enc_word_s = {bus.imm_val[31:12], bus.base_inst[11:0]};
                enc_err_s  = bus.imm_val[11:0] != 12'h000;
            end
            3'd4: begin
                enc_word_s = {bus.imm_val[20], bus.imm_val[10:1], bus.imm_val[11],
                              bus.imm_val[19:12], bus.base_inst[11:0]};
                enc_err_s  = j_range_err(bus.imm_val);
            end
            default: begin
                enc_word_s = bus.base_inst;
                enc_err_s  = 1'b1;
            end
        endcase
    end

    // In strict mode an errored request still handshakes but never enters the FIFO.
    assign full_s   = (count_r == FULL_CNT);
    assign empty_s  = (count_r == '0);
    assign accept_s = bus.in_valid && !full_s;
    assign push_s   = accept_s && !((STRICT != 0) && enc_err_s);
    assign pop_s    = !empty_s && bus.out_ready;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= 32'h0000_0000;
                err_mem_r[i]  <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                inst_mem_r[wr_ptr_r] <= enc_word_s;
                err_mem_r[wr_ptr_r]  <= enc_err_s;
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_cnt_r <= '0;
            err_cnt_r <= '0;
        end else begin
            if (accept_s && (enc_cnt_r != CNT_MAX)) begin
                enc_cnt_r <= enc_cnt_r + CNT_W'(1);
            end
            if (accept_s && enc_err_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = !full_s;
    assign bus.out_valid = !empty_s;
    assign bus.inst_out  = inst_mem_r[rd_ptr_r];
    assign bus.out_err   = err_mem_r[rd_ptr_r];
    assign bus.enc_cnt   = enc_cnt_r;
    assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a lenient DUT (STRICT=0) plus a strict DUT
// with 2-bit counters that mirrors the same requests and always drains.
module tb_imm_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_encoder_if #(.CNT_W(16)) m_if ();
    imm_encoder_if #(.CNT_W(2))  s_if ();

    imm_encoder #(.DEPTH(2), .CNT_W(16), .STRICT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    imm_encoder #(.DEPTH(2), .CNT_W(2), .STRICT(1)) dut_strict (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    assign s_if.in_valid  = m_if.in_valid;
    assign s_if.imm_sel   = m_if.imm_sel;
    assign s_if.imm_val   = m_if.imm_val;
    assign s_if.base_inst = m_if.base_inst;
    assign s_if.out_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until the lenient DUT accepts it.
    task automatic send(input string tag, input logic [2:0] sel, input logic [31:0] imm,
                        input logic [31:0] base);
        int n = 0;
        m_if.in_valid  = 1'b1;
        m_if.imm_sel   = sel;
        m_if.imm_val   = imm;
        m_if.base_inst = base;
        while (!m_if.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, {31'h0, m_if.in_ready}, 32'h1);
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] inst, input logic err);
        int n = 0;
        while (!m_if.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_vld"}, {31'h0, m_if.out_valid}, 32'h1);
        check({tag, "_inst"}, m_if.inst_out, inst);
        check({tag, "_err"}, {31'h0, m_if.out_err}, {31'h0, err});
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
    endtask

    initial begin
        m_if.in_valid  = 1'b0;
        m_if.imm_sel   = 3'd0;
        m_if.imm_val   = 32'h0;
        m_if.base_inst = 32'h0;
        m_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_vld", {31'h0, m_if.out_valid}, 32'h0);
        check("rst_rdy", {31'h0, m_if.in_ready}, 32'h1);
        check("rst_inst", m_if.inst_out, 32'h0);
        check("rst_err", {31'h0, m_if.out_err}, 32'h0);
        check("rst_enc", {16'h0, m_if.enc_cnt}, 32'h0);
        check("rst_errcnt", {16'h0, m_if.err_cnt}, 32'h0);

        // I-type, one-cycle latency
        send("i_neg1", 3'd0, 32'hFFFF_FFFF, 32'h0000_0013);
        check("i_lat_vld", {31'h0, m_if.out_valid}, 32'h1);
        expect_pop("i_neg1", 32'hFFF0_0013, 1'b0);
        check("i_empty", {31'h0, m_if.out_valid}, 32'h0);

        send("s_8", 3'd1, 32'h0000_0008, 32'h0000_2023);
        expect_pop("s_8", 32'h0000_2423, 1'b0);
        send("b_m4", 3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
        expect_pop("b_m4", 32'hFE00_0EE3, 1'b0);
        send("u_big", 3'd3, 32'h1234_5000, 32'h0000_0037);
        expect_pop("u_big", 32'h1234_5037, 1'b0);
        send("j_2048", 3'd4, 32'h0000_0800, 32'h0000_006F);
        expect_pop("j_2048", 32'h0010_006F, 1'b0);

        // Errors: encoded with truncated bits, flagged; strict DUT drops them
        send("e_i", 3'd0, 32'h0000_0800, 32'h0000_0013);
        check("e_i_strict_vld", {31'h0, s_if.out_valid}, 32'h0);
        expect_pop("e_i", 32'h8000_0013, 1'b1);
        send("e_b", 3'd2, 32'h0000_0003, 32'h0000_0063);
        check("e_b_strict_vld", {31'h0, s_if.out_valid}, 32'h0);
        expect_pop("e_b", 32'h0000_0163, 1'b1);
        send("e_u", 3'd3, 32'h0000_0001, 32'h0000_0037);
        check("e_u_strict_vld", {31'h0, s_if.out_valid}, 32'h0);
        expect_pop("e_u", 32'h0000_0037, 1'b1);
        check("e_errcnt3", {16'h0, m_if.err_cnt}, 32'd3);
        check("e_strict_errcnt3", {30'h0, s_if.err_cnt}, 32'd3);
        send("e_ill", 3'd5, 32'h0000_0000, 32'h1234_5678);
        check("e_ill_strict_vld", {31'h0, s_if.out_valid}, 32'h0);
        expect_pop("e_ill", 32'h1234_5678, 1'b1);
        check("e_enc", {16'h0, m_if.enc_cnt}, 32'd9);
        check("e_errcnt4", {16'h0, m_if.err_cnt}, 32'd4);
        check("e_strict_enc_sat", {30'h0, s_if.enc_cnt}, 32'd3);
        check("e_strict_err_sat", {30'h0, s_if.err_cnt}, 32'd3);

        // Backpressure: two fill the FIFO, third waits through a full-cycle pop
        send("bp_a", 3'd3, 32'h1111_1000, 32'h0000_0037);
        send("bp_b", 3'd3, 32'h2222_2000, 32'h0000_0037);
        check("bp_full_rdy", {31'h0, m_if.in_ready}, 32'h0);
        m_if.in_valid  = 1'b1;
        m_if.imm_val   = 32'h3333_3000;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_rdy", {31'h0, m_if.in_ready}, 32'h0);
        check("bp_hold_head", m_if.inst_out, 32'h1111_1037);
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_pop_a_head", m_if.inst_out, 32'h2222_2037);
        check("bp_no_push_enc", {16'h0, m_if.enc_cnt}, 32'd11);
        check("bp_rdy_after", {31'h0, m_if.in_ready}, 32'h1);
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        check("bp_c_head", m_if.inst_out, 32'h3333_3037);
        check("bp_c_vld", {31'h0, m_if.out_valid}, 32'h1);
        @(posedge clk); #1;
        m_if.out_ready = 1'b0;
        check("bp_drained", {31'h0, m_if.out_valid}, 32'h0);
        check("bp_enc", {16'h0, m_if.enc_cnt}, 32'd12);

        // Steady push+pop at occupancy 1
        send("pp_d", 3'd3, 32'h0000_0000, 32'h0000_0037);
        check("pp_d_head", m_if.inst_out, 32'h0000_0037);
        for (int i = 0; i < 10; i++) begin
            m_if.in_valid  = 1'b1;
            m_if.imm_sel   = 3'd3;
            m_if.imm_val   = 32'(i + 1) << 12;
            m_if.out_ready = 1'b1;
            @(posedge clk); #1;
            check($sformatf("pp_head%0d", i), m_if.inst_out, (32'(i + 1) << 12) | 32'h37);
            check($sformatf("pp_rdy%0d", i), {31'h0, m_if.in_ready}, 32'h1);
        end
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b0;
        expect_pop("pp_last", 32'h0000_A037, 1'b0);
        check("pp_empty", {31'h0, m_if.out_valid}, 32'h0);
        check("pp_enc", {16'h0, m_if.enc_cnt}, 32'd23);

        // Reset with FIFO full and a same-cycle push/pop pending
        send("r_f", 3'd0, 32'h0000_0001, 32'h0000_0013);
        send("r_g", 3'd0, 32'h0000_0002, 32'h0000_0013);
        check("r_full", {31'h0, m_if.in_ready}, 32'h0);
        rst = 1'b1;
        m_if.in_valid  = 1'b1;
        m_if.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b0;
        check("r_vld", {31'h0, m_if.out_valid}, 32'h0);
        check("r_rdy", {31'h0, m_if.in_ready}, 32'h1);
        check("r_inst", m_if.inst_out, 32'h0);
        check("r_enc", {16'h0, m_if.enc_cnt}, 32'h0);
        check("r_errcnt", {16'h0, m_if.err_cnt}, 32'h0);
        check("r_strict_enc", {30'h0, s_if.enc_cnt}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
